// File: rtl/clock_pkg.sv
// Shared types and constants for the DE2 clock time-setting controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    E_HOUR = 2'd1,
    E_MIN  = 2'd2,
    E_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FLD_HOUR = 2'b00;
  localparam logic [1:0] FLD_MIN  = 2'b01;
  localparam logic [1:0] FLD_SEC  = 2'b10;
  localparam logic [1:0] FLD_NONE = 2'b11;

  localparam logic [1:0] PRESS_NONE  = 2'b00;
  localparam logic [1:0] PRESS_SHORT = 2'b01;
  localparam logic [1:0] PRESS_LONG  = 2'b10;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      E_HOUR:  return FLD_HOUR;
      E_MIN:   return FLD_MIN;
      E_SEC:   return FLD_SEC;
      default: return FLD_NONE;
    endcase
  endfunction

  function automatic state_t next_field(input state_t s);
    case (s)
      E_HOUR:  return E_MIN;
      E_MIN:   return E_SEC;
      default: return E_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/field_step.sv
// One-step increment/decrement of a time field with wrap at 0 and MAX.
module field_step #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (inc) begin
      next_value = (value == W'(MAX)) ? '0 : value + 1'b1;
    end else if (dec) begin
      next_value = (value == '0) ? W'(MAX) : value - 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit-session controller: MODE/ADJ press codes drive field selection, adjust,
// blink and a single-cycle commit strobe into the timekeeping counters.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_CYC   = 12_500_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [1:0] mode_state,
  input  logic [1:0] adj_state,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       edit_active,
  output logic [1:0] field_sel,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic [5:0] edit_sec,
  output logic       blink,
  output logic       time_load
);

  state_t           state, state_n;
  logic [4:0]       hour_n, step_hour;
  logic [5:0]       min_n, step_min;
  logic [5:0]       sec_n, step_sec;
  logic [CNT_W-1:0] idle_cnt, idle_n;
  logic [CNT_W-1:0] blink_cnt, bcnt_n;
  logic             blink_n, load_n;

  logic mode_short, mode_long, adj_short, adj_long, adj_inc, adj_dec;

  assign mode_short = (mode_state == PRESS_SHORT);
  assign mode_long  = (mode_state == PRESS_LONG);
  assign adj_short  = (adj_state == PRESS_SHORT);
  assign adj_long   = (adj_state == PRESS_LONG);
  // A mode code in the same cycle swallows any adj code.
  assign adj_inc    = adj_short & ~(mode_short | mode_long);
  assign adj_dec    = adj_long & ~(mode_short | mode_long);

  assign edit_active = (state != RUN);
  assign field_sel   = field_of(state);

  field_step #(.MAX(HOUR_MAX), .W(5)) u_step_hour (
    .value(edit_hour), .inc(adj_inc & (state == E_HOUR)),
    .dec(adj_dec & (state == E_HOUR)), .next_value(step_hour)
  );
  field_step #(.MAX(MINSEC_MAX), .W(6)) u_step_min (
    .value(edit_min), .inc(adj_inc & (state == E_MIN)),
    .dec(adj_dec & (state == E_MIN)), .next_value(step_min)
  );
  field_step #(.MAX(MINSEC_MAX), .W(6)) u_step_sec (
    .value(edit_sec), .inc(adj_inc & (state == E_SEC)),
    .dec(adj_dec & (state == E_SEC)), .next_value(step_sec)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      edit_sec  <= '0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      time_load <= 1'b0;
    end else begin
      state     <= state_n;
      edit_hour <= hour_n;
      edit_min  <= min_n;
      edit_sec  <= sec_n;
      idle_cnt  <= idle_n;
      blink_cnt <= bcnt_n;
      blink     <= blink_n;
      time_load <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    hour_n  = step_hour;
    min_n   = step_min;
    sec_n   = step_sec;
    idle_n  = idle_cnt;
    bcnt_n  = blink_cnt;
    blink_n = blink;
    load_n  = 1'b0;
    if (state == RUN) begin
      idle_n  = '0;
      bcnt_n  = '0;
      blink_n = 1'b0;
      if (mode_long) begin
        state_n = E_HOUR;
        blink_n = 1'b1;
        // Out-of-range live time is captured as zero.
        hour_n  = (cur_hour > 5'(HOUR_MAX))   ? '0 : cur_hour;
        min_n   = (cur_min  > 6'(MINSEC_MAX)) ? '0 : cur_min;
        sec_n   = (cur_sec  > 6'(MINSEC_MAX)) ? '0 : cur_sec;
      end
    end else if (mode_long) begin
      state_n = RUN;
      load_n  = 1'b1;
      idle_n  = '0;
      bcnt_n  = '0;
      blink_n = 1'b0;
    end else if (mode_short || adj_short || adj_long) begin
      if (mode_short) state_n = next_field(state);
      idle_n  = '0;
      bcnt_n  = '0;
      blink_n = 1'b1;
    end else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      state_n = RUN;
      idle_n  = '0;
      bcnt_n  = '0;
      blink_n = 1'b0;
    end else begin
      idle_n = idle_cnt + 1'b1;
      if (blink_cnt == CNT_W'(BLINK_CYC - 1)) begin
        bcnt_n  = '0;
        blink_n = ~blink;
      end else begin
        bcnt_n = blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a session-level reference model.
module tb_clock_set_ctrl;

  localparam int BLINK   = 4;
  localparam int TIMEOUT = 50;

  logic       CLOCK_50;
  logic       rst_n;
  logic [1:0] mode_state, adj_state;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic       edit_active, blink, time_load;
  logic [1:0] field_sel;
  logic [4:0] edit_hour;
  logic [5:0] edit_min, edit_sec;

  clock_set_ctrl #(.BLINK_CYC(BLINK), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .mode_state(mode_state), .adj_state(adj_state),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .edit_active(edit_active), .field_sel(field_sel), .edit_hour(edit_hour),
    .edit_min(edit_min), .edit_sec(edit_sec), .blink(blink), .time_load(time_load)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  // model: a session is either open or closed, with a field index and an age
  bit m_editing, m_load;
  int m_field, m_h, m_m, m_s, m_idle, m_age;
  logic [21:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_editing = 0; m_load = 0; m_field = 0;
    m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_age = 0;
  endtask

  task automatic model_adjust(input int d);
    case (m_field)
      0:       m_h = (m_h + 24 + d) % 24;
      1:       m_m = (m_m + 60 + d) % 60;
      default: m_s = (m_s + 60 + d) % 60;
    endcase
  endtask

  task automatic model_step(input logic [1:0] m, input logic [1:0] a);
    logic [21:0] e;
    logic [1:0]  fs;
    logic        bl;
    m_load = 0;
    if (!m_editing) begin
      if (m == 2'd2) begin
        m_editing = 1; m_field = 0; m_idle = 0; m_age = 0;
        m_h = (cur_hour < 24) ? int'(cur_hour) : 0;
        m_m = (cur_min  < 60) ? int'(cur_min)  : 0;
        m_s = (cur_sec  < 60) ? int'(cur_sec)  : 0;
      end
    end else if (m == 2'd2) begin
      m_load = 1; m_editing = 0;
    end else if (m == 2'd1) begin
      m_field = (m_field + 1) % 3; m_idle = 0; m_age = 0;
    end else if (a == 2'd1 || a == 2'd2) begin
      model_adjust((a == 2'd1) ? 1 : -1); m_idle = 0; m_age = 0;
    end else if (m_idle == TIMEOUT - 1) begin
      m_editing = 0;
    end else begin
      m_idle++; m_age++;
    end
    fs = m_editing ? 2'(m_field) : 2'b11;
    bl = m_editing && (((m_age / BLINK) % 2) == 0);
    e  = {m_editing, fs, bl, m_load, 5'(m_h), 6'(m_m), 6'(m_s)};
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs();
    logic [21:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("edit_active", edit_active, e[21]);
      check("field_sel",   field_sel,   e[20:19]);
      check("blink",       blink,       e[18]);
      check("time_load",   time_load,   e[17]);
      check("edit_hour",   edit_hour,   e[16:12]);
      check("edit_min",    edit_min,    e[11:6]);
      check("edit_sec",    edit_sec,    e[5:0]);
    end
  endtask

  // driver
  task automatic cycle(input logic [1:0] m, input logic [1:0] a);
    mode_state = m;
    adj_state  = a;
    @(posedge CLOCK_50);
    model_step(m, a);
    #1;
    mode_state = 2'b00;
    adj_state  = 2'b00;
    compare_outputs();
  endtask

  function automatic int model_val();
    case (m_field)
      0:       return m_h;
      1:       return m_m;
      default: return m_s;
    endcase
  endfunction

  task automatic set_to(input int target);
    for (int k = 0; k < 70 && model_val() != target; k++) cycle(2'b00, 2'b01);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_active"}, edit_active, 0);
    check({tag, "_field"},  field_sel,   3);
    check({tag, "_hour"},   edit_hour,   0);
    check({tag, "_min"},    edit_min,    0);
    check({tag, "_sec"},    edit_sec,    0);
    check({tag, "_blink"},  blink,       0);
    check({tag, "_load"},   time_load,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int loads, stop_at;
    int r;
    logic [1:0] m, a;
    rst_n = 1'b0; mode_state = 2'b00; adj_state = 2'b00;
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    #1;
    check_reset_values("reset");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;

    // entry
    cycle(2'b01, 2'b00);
    check("run_short_ignored", edit_active, 0);
    cycle(2'b00, 2'b10);
    check("run_adj_ignored", edit_hour, 0);
    cycle(2'b10, 2'b00);
    check("entry_active", edit_active, 1);
    check("entry_field", field_sel, 0);
    check("entry_time", {edit_hour, edit_min, edit_sec}, {5'd12, 6'd34, 6'd56});
    check("entry_blink", blink, 1);

    // wraps
    set_to(23);
    cycle(2'b00, 2'b01); check("hour_wrap_up", edit_hour, 0);
    cycle(2'b00, 2'b10); check("hour_wrap_dn", edit_hour, 23);
    cycle(2'b01, 2'b00); check("to_min", field_sel, 1);
    set_to(0);
    cycle(2'b00, 2'b10); check("min_wrap_dn", edit_min, 59);
    cycle(2'b01, 2'b00); check("to_sec", field_sel, 2);
    set_to(59);
    cycle(2'b00, 2'b01); check("sec_wrap_up", edit_sec, 0);
    cycle(2'b01, 2'b00); check("sec_to_hour", field_sel, 0);

    // field cycling and commit
    set_to(7);  cycle(2'b01, 2'b00); check("cyc_min", field_sel, 1);
    set_to(8);  cycle(2'b01, 2'b00); check("cyc_sec", field_sel, 2);
    set_to(9);  cycle(2'b01, 2'b00); check("cyc_hour", field_sel, 0);
    cycle(2'b10, 2'b00);
    check("commit_load", time_load, 1);
    check("commit_time", {edit_hour, edit_min, edit_sec}, {5'd7, 6'd8, 6'd9});
    check("commit_active", edit_active, 0);
    check("commit_field", field_sel, 3);
    check("commit_blink", blink, 0);
    cycle(2'b00, 2'b00);
    check("commit_load_once", time_load, 0);
    check("commit_hold", {edit_hour, edit_min, edit_sec}, {5'd7, 6'd8, 6'd9});

    // priority
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    cycle(2'b10, 2'b00);
    cycle(2'b01, 2'b01);
    check("prio_field", field_sel, 1);
    check("prio_hour", edit_hour, 12);
    cycle(2'b10, 2'b00);

    // timeout without presses
    cycle(2'b10, 2'b00);
    loads = 0; stop_at = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle(2'b00, 2'b00);
      loads += int'(time_load);
      if (i == 4) check("blink_low", blink, 0);
      if (i == 8) check("blink_high", blink, 1);
      if (!edit_active) begin stop_at = i; break; end
    end
    check("abort_cycle", stop_at, 50);
    check("abort_no_load", loads, 0);

    // press at cycle 40 extends the session
    cycle(2'b10, 2'b00);
    for (int i = 1; i < 40; i++) cycle(2'b00, 2'b00);
    cycle(2'b00, 2'b01);
    check("press_blink", blink, 1);
    stop_at = 0; loads = 0;
    for (int i = 41; i <= 200; i++) begin
      cycle(2'b00, 2'b00);
      loads += int'(time_load);
      if (!edit_active) begin stop_at = i; break; end
    end
    check("extend_cycle", stop_at, 90);
    check("extend_no_load", loads, 0);

    // asynchronous reset mid-edit
    cycle(2'b10, 2'b00);
    cycle(2'b01, 2'b00);
    cycle(2'b01, 2'b00);
    check("pre_reset_sec", field_sel, 2);
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(2'b00, 2'b00);
      loads += int'(time_load);
    end
    check("post_reset_no_load", loads, 0);

    // random traffic, busy then sparse to reach timeouts
    for (int i = 0; i < 4000; i++) begin
      cur_hour = 5'($urandom_range(0, 31));
      cur_min  = 6'($urandom_range(0, 63));
      cur_sec  = 6'($urandom_range(0, 63));
      r = $urandom_range(0, 99);
      if (i < 3000) begin
        m = (r < 3) ? 2'b10 : (r < 8) ? 2'b01 : (r < 10) ? 2'b11 : 2'b00;
        r = $urandom_range(0, 99);
        a = (r < 15) ? 2'b01 : (r < 25) ? 2'b10 : (r < 28) ? 2'b11 : 2'b00;
      end else begin
        m = (r < 2) ? 2'b10 : (r < 3) ? 2'b01 : 2'b00;
        r = $urandom_range(0, 99);
        a = (r < 1) ? 2'b01 : (r < 2) ? 2'b10 : 2'b00;
      end
      cycle(m, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
